// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave receiver: synchronizes SCL/SDA, detects START/STOP,
// ACKs its own address and every data byte, and presents each byte on rx_data.
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h24,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    input  logic       i2c_sda,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_ACK_ADDR  = 3'd2,
        S_DATA      = 3'd3,
        S_ACK_DATA  = 3'd4,
        S_WAIT_STOP = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_r, sda_sync_r;
    logic                   scl_d_r, sda_d_r;
    logic                   scl_s, sda_s;
    logic                   scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [7:0]             byte_s;
    logic                   last_bit_s;

    state_t     state_r, state_nxt;
    logic [2:0] bit_cnt_r, bit_cnt_nxt;
    logic [6:0] shift_r, shift_nxt;
    logic       ack_drive_r, ack_drive_nxt;
    logic       sda_oe_r, sda_oe_nxt;
    logic       addr_match_r, addr_match_nxt;
    logic [7:0] rx_data_r, rx_data_nxt;
    logic       rx_valid_r, rx_valid_nxt;
    logic       busy_r;

    // Input synchronizers plus one delay stage; reset to 1 so an idle bus shows no edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_r <= '1;
            sda_sync_r <= '1;
            scl_d_r    <= 1'b1;
            sda_d_r    <= 1'b1;
        end else begin
            scl_sync_r[0] <= i2c_scl;
            sda_sync_r[0] <= i2c_sda;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                scl_sync_r[i] <= scl_sync_r[i-1];
                sda_sync_r[i] <= sda_sync_r[i-1];
            end
            scl_d_r <= scl_sync_r[SYNC_STAGES-1];
            sda_d_r <= sda_sync_r[SYNC_STAGES-1];
        end
    end

    assign scl_s      = scl_sync_r[SYNC_STAGES-1];
    assign sda_s      = sda_sync_r[SYNC_STAGES-1];
    assign scl_rise_s = scl_s & ~scl_d_r;
    assign scl_fall_s = ~scl_s & scl_d_r;
    assign start_s    = scl_s & sda_d_r & ~sda_s;
    assign stop_s     = scl_s & ~sda_d_r & sda_s;
    assign byte_s     = {shift_r, sda_s};
    assign last_bit_s = scl_rise_s && (bit_cnt_r == 3'd0);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 7'd0;
            ack_drive_r  <= 1'b0;
            sda_oe_r     <= 1'b0;
            addr_match_r <= 1'b0;
            rx_data_r    <= 8'h00;
            rx_valid_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt;
            bit_cnt_r    <= bit_cnt_nxt;
            shift_r      <= shift_nxt;
            ack_drive_r  <= ack_drive_nxt;
            sda_oe_r     <= sda_oe_nxt;
            addr_match_r <= addr_match_nxt;
            rx_data_r    <= rx_data_nxt;
            rx_valid_r   <= rx_valid_nxt;
            busy_r       <= (state_nxt != S_IDLE);
        end
    end

    // Next-state logic; STOP outranks START, both outrank the byte sequencing.
    always_comb begin
        state_nxt = state_r;
        if (stop_s) begin
            state_nxt = S_IDLE;
        end else if (start_s) begin
            state_nxt = S_ADDR;
        end else begin
            case (state_r)
                S_IDLE: state_nxt = S_IDLE;
                S_ADDR: begin
                    if (last_bit_s) begin
                        if ((byte_s[7:1] == SLAVE_ADDR) && (byte_s[0] == 1'b0)) begin
                            state_nxt = S_ACK_ADDR;
                        end else begin
                            state_nxt = S_WAIT_STOP;
                        end
                    end else begin
                        state_nxt = S_ADDR;
                    end
                end
                S_ACK_ADDR, S_ACK_DATA: begin
                    if (scl_fall_s && ack_drive_r) begin
                        state_nxt = S_DATA;
                    end else begin
                        state_nxt = state_r;
                    end
                end
                S_DATA: begin
                    if (last_bit_s) begin
                        state_nxt = S_ACK_DATA;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
                S_WAIT_STOP: state_nxt = S_WAIT_STOP;
                default:     state_nxt = S_IDLE;
            endcase
        end
    end

    // Output/datapath next values: shifting, ACK slot drive, byte delivery.
    always_comb begin
        bit_cnt_nxt    = bit_cnt_r;
        shift_nxt      = shift_r;
        ack_drive_nxt  = ack_drive_r;
        sda_oe_nxt     = sda_oe_r;
        addr_match_nxt = addr_match_r;
        rx_data_nxt    = rx_data_r;
        rx_valid_nxt   = 1'b0;
        if (stop_s) begin
            bit_cnt_nxt    = 3'd0;
            ack_drive_nxt  = 1'b0;
            sda_oe_nxt     = 1'b0;
            addr_match_nxt = 1'b0;
        end else if (start_s) begin
            // Counter indexes the bit position, so a fresh byte starts at 7.
            bit_cnt_nxt    = 3'd7;
            ack_drive_nxt  = 1'b0;
            sda_oe_nxt     = 1'b0;
            addr_match_nxt = 1'b0;
        end else begin
            case (state_r)
                S_ADDR, S_DATA: begin
                    if (scl_rise_s) begin
                        shift_nxt   = byte_s[6:0];
                        bit_cnt_nxt = bit_cnt_r - 3'd1;
                        if ((state_r == S_DATA) && (bit_cnt_r == 3'd0)) begin
                            rx_data_nxt  = byte_s;
                            rx_valid_nxt = 1'b1;
                        end else begin
                            rx_valid_nxt = 1'b0;
                        end
                    end else begin
                        shift_nxt = shift_r;
                    end
                end
                S_ACK_ADDR, S_ACK_DATA: begin
                    // First falling edge opens the ACK slot, the second closes it.
                    if (scl_fall_s) begin
                        if (!ack_drive_r) begin
                            ack_drive_nxt = 1'b1;
                            sda_oe_nxt    = 1'b1;
                            if (state_r == S_ACK_ADDR) begin
                                addr_match_nxt = 1'b1;
                            end else begin
                                addr_match_nxt = addr_match_r;
                            end
                        end else begin
                            ack_drive_nxt = 1'b0;
                            sda_oe_nxt    = 1'b0;
                            bit_cnt_nxt   = 3'd7;
                        end
                    end else begin
                        ack_drive_nxt = ack_drive_r;
                    end
                end
                default: sda_oe_nxt = 1'b0;
            endcase
        end
    end

    assign sda_oe     = sda_oe_r;
    assign rx_data    = rx_data_r;
    assign rx_valid   = rx_valid_r;
    assign addr_match = addr_match_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-banged I2C master, transaction-level model and
// a scoreboard monitor that checks every rx_valid byte against the queue.
module tb_i2c_slave_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda = 1'b1;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_match;
    logic       busy;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    logic       allow_oe = 1'b0;
    int         oe_viol = 0;
    logic       prev_valid = 1'b0;
    logic       model_matched = 1'b0;

    i2c_slave_rx #(.SLAVE_ADDR(7'h24), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .i2c_scl(scl), .i2c_sda(sda),
        .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .addr_match(addr_match), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops expected bytes whenever the DUT presents one.
    always @(negedge clk) begin
        if (sda_oe && !allow_oe) oe_viol++;
        if (rx_valid) begin
            check("rx_valid_width", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx_unexpected: got %0h want none", rx_data);
            end else begin
                check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_valid = rx_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_cond();
        sda = 1'b1; tick(4);
        scl = 1'b1; tick(4);
        sda = 1'b0; tick(4);
        scl = 1'b0; tick(4);
        model_matched = 1'b0;
    endtask

    task automatic stop_cond();
        sda = 1'b0; tick(4);
        scl = 1'b1; tick(4);
        sda = 1'b1; tick(6);
        model_matched = 1'b0;
        check("stop_busy", {31'd0, busy}, 32'd0);
        check("stop_addr_match", {31'd0, addr_match}, 32'd0);
        check("oe_outside_ack", oe_viol, 32'd0);
        check("pending_bytes", exp_q.size(), 32'd0);
    endtask

    task automatic send_bit(input logic b);
        sda = b;    tick(4);
        scl = 1'b1; tick(8);
        scl = 1'b0; tick(4);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit is_addr);
        logic exp_ack;
        exp_ack = is_addr ? ((b[7:1] == 7'h24) && (b[0] == 1'b0)) : model_matched;
        if (!is_addr && model_matched) exp_q.push_back(b);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) allow_oe = exp_ack;
            send_bit(b[i]);
        end
        // Ninth clock: master releases SDA and the slave may ACK.
        sda = 1'b1; tick(4);
        scl = 1'b1; tick(4);
        check(is_addr ? "addr_ack" : "data_ack", {31'd0, sda_oe}, {31'd0, exp_ack});
        tick(4);
        scl = 1'b0; tick(6);
        allow_oe = 1'b0;
        if (is_addr) begin
            model_matched = exp_ack;
            check("addr_match", {31'd0, addr_match}, {31'd0, exp_ack});
            check("busy_after_addr", {31'd0, busy}, 32'd1);
        end
    endtask

    initial begin
        logic [7:0] abyte;
        logic [7:0] d;
        int         nb;
        bit         partial;

        tick(3);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_addr_match", {31'd0, addr_match}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick(6);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Single byte to our address.
        start_cond(); send_byte(8'h48, 1'b1); send_byte(8'h0F, 1'b0); stop_cond();
        check("hold_rx_data", {24'd0, rx_data}, 32'h0F);

        // Wrong address: no ACK, waits for STOP.
        start_cond(); send_byte(8'h4A, 1'b1); send_byte(8'hAA, 1'b0);
        check("wait_stop_busy", {31'd0, busy}, 32'd1);
        stop_cond();

        // Read request is NACKed.
        start_cond(); send_byte(8'h49, 1'b1); stop_cond();

        // Multi-byte write.
        start_cond(); send_byte(8'h48, 1'b1);
        send_byte(8'h12, 1'b0); send_byte(8'h34, 1'b0); send_byte(8'h56, 1'b0);
        stop_cond();

        // Partial byte then repeated START.
        start_cond(); send_byte(8'h48, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        start_cond(); send_byte(8'h48, 1'b1); send_byte(8'hC3, 1'b0); stop_cond();
        check("rs_rx_data", {24'd0, rx_data}, 32'hC3);

        // Reset in the middle of a data byte.
        start_cond(); send_byte(8'h48, 1'b1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        reset = 1'b1;
        tick(1);
        check("mid_rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("mid_rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("mid_rst_addr_match", {31'd0, addr_match}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        model_matched = 1'b0;
        tick(6);
        start_cond(); send_byte(8'h48, 1'b1); send_byte(8'h5A, 1'b0); stop_cond();
        check("post_rst_rx_data", {24'd0, rx_data}, 32'h5A);

        // Randomized transactions, some ending in repeated START.
        partial = 1'b0;
        for (int t = 0; t < 20; t++) begin
            start_cond();
            abyte[7:1] = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h24;
            abyte[0]   = ($urandom_range(0, 4) == 0);
            send_byte(abyte, 1'b1);
            nb = $urandom_range(1, 3);
            for (int k = 0; k < nb; k++) begin
                d = 8'($urandom);
                send_byte(d, 1'b0);
            end
            partial = ($urandom_range(0, 3) == 0);
            if (partial) begin
                for (int k = 0; k < $urandom_range(1, 7); k++) send_bit(1'($urandom));
            end else begin
                stop_cond();
            end
        end
        if (partial) stop_cond();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
